// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment vector type, active-low glyph
// constants (also used by the display encoder) and the capture FSM states.
// No ports; imported by the capture interface, decoder and top level.
package seg_pkg;

  // Bit 6 = segment a ... bit 0 = segment g, active low.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK  = 7'b1111111;
  localparam seg_t SEG_HEX_0  = 7'b0000001;
  localparam seg_t SEG_HEX_1  = 7'b1001111;
  localparam seg_t SEG_HEX_2  = 7'b0010010;
  localparam seg_t SEG_HEX_3  = 7'b0000110;
  localparam seg_t SEG_HEX_4  = 7'b1001100;
  localparam seg_t SEG_HEX_5  = 7'b0100100;
  localparam seg_t SEG_HEX_6  = 7'b0100000;
  localparam seg_t SEG_HEX_7  = 7'b0001111;
  localparam seg_t SEG_HEX_8  = 7'b0000000;
  localparam seg_t SEG_HEX_9  = 7'b0000100;
  localparam seg_t SEG_HEX_A  = 7'b0001000;
  localparam seg_t SEG_HEX_B  = 7'b1100000;
  localparam seg_t SEG_HEX_C  = 7'b0110001;
  localparam seg_t SEG_HEX_D  = 7'b1000010;
  localparam seg_t SEG_HEX_E  = 7'b0110000;
  localparam seg_t SEG_HEX_F  = 7'b0111000;

  typedef enum logic {
    SYNC = 1'b0,
    HOLD = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Display observation bus: pin-level segment/enable lines in, published frame out.
// Ports: seg/an (active-low pins, driven by the display side = master);
//        digits/digit_valid/frame_done/pattern_err (driven by the capture block = slave).
interface seven_seg_capture_if;
  import seg_pkg::*;

  seg_t        seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        pattern_err;

  modport master (
    output seg, an,
    input  digits, digit_valid, frame_done, pattern_err
  );

  modport slave (
    input  seg, an,
    output digits, digit_valid, frame_done, pattern_err
  );

endinterface

// File: rtl/seven_seg_decode.sv
// Combinational seven-segment glyph to hex nibble decoder.
// Ports: seg_i (active-low a..g) -> nibble_o, valid_o (legal hex glyph),
//        err_o (neither hex nor blank). Blank gives nibble 0, not valid, no error.
module seven_seg_decode
  import seg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] nibble_o,
  output logic       valid_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = 4'h0;
    valid_o  = 1'b1;
    err_o    = 1'b0;
    case (seg_i)
      SEG_HEX_0: nibble_o = 4'h0;
      SEG_HEX_1: nibble_o = 4'h1;
      SEG_HEX_2: nibble_o = 4'h2;
      SEG_HEX_3: nibble_o = 4'h3;
      SEG_HEX_4: nibble_o = 4'h4;
      SEG_HEX_5: nibble_o = 4'h5;
      SEG_HEX_6: nibble_o = 4'h6;
      SEG_HEX_7: nibble_o = 4'h7;
      SEG_HEX_8: nibble_o = 4'h8;
      SEG_HEX_9: nibble_o = 4'h9;
      SEG_HEX_A: nibble_o = 4'hA;
      SEG_HEX_B: nibble_o = 4'hB;
      SEG_HEX_C: nibble_o = 4'hC;
      SEG_HEX_D: nibble_o = 4'hD;
      SEG_HEX_E: nibble_o = 4'hE;
      SEG_HEX_F: nibble_o = 4'hF;
      SEG_BLANK: valid_o  = 1'b0;
      default: begin
        valid_o = 1'b0;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Reconstructs the four hex digits shown on a multiplexed active-low 7-seg bus.
// Ports: clk, reset_n (async active-low), bus (slave modport: seg/an in;
//        digits/digit_valid/frame_done/pattern_err out, all registered).
module seven_seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  seven_seg_capture_if.slave  bus
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // Synchronisers idle at all-ones (no digit enabled, all segments off).
  seg_t        seg_m_q, seg_s_q;
  logic [3:0]  an_m_q, an_s_q;

  logic [10:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  fsm_state_e  state_q;

  logic [15:0] sh_nib_q, sh_nib_d;
  logic [3:0]  sh_val_q, sh_val_d;
  logic [3:0]  seen_q, seen_d;

  logic [15:0] digits_q;
  logic [3:0]  digit_valid_q;
  logic        frame_done_q;
  logic        pattern_err_q;

  logic [10:0] cur;
  logic        changed;
  logic [3:0]  an_hot;
  logic        one_hot;
  logic        capture;
  logic [3:0]  dec_nib;
  logic        dec_val;
  logic        dec_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_m_q <= SEG_BLANK;
      seg_s_q <= SEG_BLANK;
      an_m_q  <= 4'hF;
      an_s_q  <= 4'hF;
    end else begin
      seg_m_q <= bus.seg;
      seg_s_q <= seg_m_q;
      an_m_q  <= bus.an;
      an_s_q  <= an_m_q;
    end
  end

  seven_seg_decode u_decode (
    .seg_i    (seg_s_q),
    .nibble_o (dec_nib),
    .valid_o  (dec_val),
    .err_o    (dec_err)
  );

  assign cur     = {an_s_q, seg_s_q};
  assign changed = (cur != prev_q);
  assign an_hot  = ~an_s_q;
  assign one_hot = (an_hot != 4'h0) && ((an_hot & (an_hot - 4'd1)) == 4'h0);

  // cnt_d counts consecutive cycles with an unchanged synchronised bus.
  always_comb begin
    cnt_d = cnt_q;
    if (changed)
      cnt_d = 8'd0;
    else if (cnt_q < STABLE)
      cnt_d = cnt_q + 8'd1;
  end

  // Capture on the edge the counter reaches the threshold; cnt_d == STABLE
  // already implies the bus did not change this cycle.
  assign capture = (state_q == SYNC) && (cnt_d == STABLE) && one_hot;

  // Shadow contents as they would be after capturing the current digit.
  always_comb begin
    sh_nib_d = sh_nib_q;
    sh_val_d = sh_val_q;
    for (int i = 0; i < 4; i++) begin
      if (an_hot[i]) begin
        sh_nib_d[4*i +: 4] = dec_nib;
        sh_val_d[i]        = dec_val;
      end
    end
    seen_d = seen_q | an_hot;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q        <= {4'hF, SEG_BLANK};
      cnt_q         <= 8'd0;
      state_q       <= SYNC;
      sh_nib_q      <= 16'h0000;
      sh_val_q      <= 4'h0;
      seen_q        <= 4'h0;
      digits_q      <= 16'h0000;
      digit_valid_q <= 4'h0;
      frame_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      prev_q        <= cur;
      cnt_q         <= cnt_d;
      frame_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
      case (state_q)
        SYNC: begin
          if (capture) begin
            state_q       <= HOLD;
            sh_nib_q      <= sh_nib_d;
            sh_val_q      <= sh_val_d;
            pattern_err_q <= dec_err;
            if (seen_d == 4'hF) begin
              digits_q      <= sh_nib_d;
              digit_valid_q <= sh_val_d;
              frame_done_q  <= 1'b1;
              seen_q        <= 4'h0;
            end else begin
              seen_q        <= seen_d;
            end
          end
        end
        HOLD: begin
          if (changed)
            state_q <= SYNC;
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.pattern_err = pattern_err_q;

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Reads a multiplexed, active-low four-digit seven-segment display bus (segment lines plus digit enables) and reconstructs the hex value shown on each digit. It sits on the observation side of the display path: it turns the pin-level waveform from the display driver back into nibbles for self-check, loopback test and logging. It synchronises the bus, waits for each digit to be stable, decodes it, and publishes a complete four-digit frame once every digit has been captured.

## Interface
- STABLE_CYCLES, default 4: consecutive identical synchronised samples required before a digit is captured. Legal range is 1..255.
- clk  input  1  single system clock
- reset_n  input  1  asynchronous, active-low reset
- seg  input  7  active-low segments. Bit 6 = a through bit 0 = g. Asynchronous to clk.
- an  input  4  active-low digit enables. Bit i selects digit i. Asynchronous to clk.
- digits  output  16  published frame. Nibble i is at [4i+3:4i]. Reset value 16'h0000.
- digit_valid  output  4  per-digit flag for the published frame; bit i = digit i held a legal hex pattern. Reset value 4'h0.
- frame_done  output  1  one-cycle pulse when digits/digit_valid update. Reset value 0.
- pattern_err  output  1  one-cycle pulse when a captured pattern is neither hex nor blank. Reset value 0.

## Operation
- seg and an each pass through a 2-flop synchroniser. All further logic uses the synchronised values s_seg and s_an.
- Stability counter:
  - Cleared when {s_an,s_seg} differs from the previous cycle; otherwise increments.
  - Saturates at STABLE_CYCLES.
- FSM states:
  - SYNC → HOLD when the counter reaches STABLE_CYCLES and s_an is one-hot-low (exactly one bit 0). The digit is captured on this transition.
  - HOLD → SYNC on any change of {s_an,s_seg}.
  - An s_an value with zero or multiple low bits never captures; the FSM stays in SYNC.
- Capture of digit i writes shadow nibble i and shadow valid i, and sets seen[i].
- Decode, active low, pattern a..g → nibble:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→b
  - 0110001→C, 1000010→d, 0110000→E, 0111000→F
- 1111111 (blank): nibble 0, valid 0, no error.
- Any other pattern: nibble 0, valid 0, pattern_err pulses.
- A re-capture of an already-seen digit before the frame completes overwrites that digit's shadow entry.
- When a capture makes seen == 4'hF:
  - Shadow values, including the capture just made, copy to digits/digit_valid.
  - frame_done pulses and seen clears to 0.
- Published outputs hold between frames.

## Timing
- Bus stable from edge k: s_* is valid after edge k+2. Capture occurs on edge k+2+STABLE_CYCLES, plus 1 if the counter was not already clear (the value changed).
- frame_done and pattern_err are registered and are high for the single cycle after the capturing edge. digits is valid in that same cycle.
- A digit held for a long time is captured once per HOLD entry, never repeatedly.
- A change that lasts fewer than STABLE_CYCLES synchronised cycles (ghosting during an enable switch) is ignored.
- Asserting reset_n low mid-frame clears, asynchronously:
  - the synchronisers, counter, seen, shadow and FSM (to SYNC);
  - all outputs.
  The first frame after reset requires all four digits again.

## Structure
- Package seg_pkg:
  - seg_t (logic [6:0]);
  - SEG_BLANK and the sixteen SEG_HEX_0..F pattern constants, shared with the display encoder;
  - fsm state enum {SYNC, HOLD}.
- Sub-module seven_seg_decode: purely combinational seg_t → {nibble, valid, err}. It can be unit-tested against the encoder output by exhaustive loopback.
- The top level holds the synchronisers, counter, FSM, shadow/seen registers and output registers.

## Test plan
- Reset check: reset_n low with random bus activity → digits=0, digit_valid=0, frame_done=0, pattern_err=0.
- Normal frame, STABLE_CYCLES=4: drive an=1110/1101/1011/0111 with patterns for 1,2,3,4, 20 cycles each → one frame_done, digits=16'h4321, digit_valid=4'hF.
- Glitch rejection: insert a 2-cycle an=1100 and a 3-cycle stray seg value between digits → no capture, no pattern_err; the frame still yields 16'h4321.
- Blank and error handling:
  - Digit 2 blank (1111111) → digit_valid=4'hB, nibble 2 = 0, no pattern_err.
  - Digit 0 = 1111110 → pattern_err pulses once and digit_valid[0]=0.
- Loopback: sweep all 16 nibbles through the display encoder into each digit position → every published nibble matches and digit_valid bit=1.
- Reset mid-frame after digits 0 and 1 are captured → no frame_done until all four digits are recaptured after release.
